// File: rtl/regfile_multiport.sv
// Parametrised multi-read/single-write register file with registered, stallable
// read ports, optional write-to-read bypass, hard-wired zero register and two state taps.

module regfile_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] arr_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data
);
    logic [DATA_WIDTH-1:0] nxt;

    // Zero-register override is applied last so it beats bypass of a suppressed write.
    always_comb begin
        nxt = arr_data;
        if (BYPASS != 0 && wr_en && wr_addr == addr)
            nxt = wr_data;
        if (ZERO_REG != 0 && addr == '0)
            nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data <= '0;
        else if (en)
            data <= nxt;
    end
endmodule

module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int TAP_A_IDX  = 2,
    parameter int TAP_B_IDX  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic [DATA_WIDTH-1:0]          tap_a,
    output logic [DATA_WIDTH-1:0]          tap_b,
    output logic                           wr_zero_err
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic                                wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs        <= '0;
            wr_zero_err <= 1'b0;
        end else begin
            wr_zero_err <= wr_en && wr_zero;
            if (wr_en && !wr_zero)
                regs[wr_addr] <= wr_data;
        end
    end

    // Taps read straight from state; no bypass.
    assign tap_a = regs[TAP_A_IDX];
    assign tap_b = regs[TAP_B_IDX];

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .en      (rd_en[i]),
            .addr    (addr),
            .arr_data(regs[addr]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: a bypassing and a non-bypassing instance
// share one stimulus stream; all expectations are hand-computed constants.

module tb_regfile_multiport;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_data_nb;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   tap_a, tap_b, tap_a_nb, tap_b_nb;
    logic            wr_zero_err, wr_zero_err_nb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tap_a(tap_a), .tap_b(tap_b), .wr_zero_err(wr_zero_err)
    );

    regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tap_a(tap_a_nb), .tap_b(tap_b_nb), .wr_zero_err(wr_zero_err_nb)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        rst = 1'b1;
        set_rd(2'b11, 5'd0, 5'd0);
        set_wr(1'b0, 5'd0, 32'h0);
        #12;
        chk("reset_rd0", rd_data[31:0], 32'h0);
        chk("reset_rd1", rd_data[63:32], 32'h0);
        chk("reset_tap_a", tap_a, 32'h0);
        chk("reset_tap_b", tap_b, 32'h0);
        chk("reset_err", {31'h0, wr_zero_err}, 32'h0);
        step();
        rst = 1'b0;

        // every address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            set_rd(2'b11, a[AW-1:0], 5'(31 - a));
            step();
            chk("sweep_rd0", rd_data[31:0], 32'h0);
            chk("sweep_rd1", rd_data[63:32], 32'h0);
        end

        // write then read on a later edge
        set_rd(2'b11, 5'd0, 5'd0);
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b11, 5'd5, 5'd0);
        step();
        chk("wr_rd_r5", rd_data[31:0], 32'hDEADBEEF);
        chk("wr_rd_r5_nb", rd_data_nb[31:0], 32'hDEADBEEF);

        // same-edge write and read of r7 on both ports
        set_wr(1'b1, 5'd7, 32'h12345678);
        set_rd(2'b11, 5'd7, 5'd7);
        step();
        chk("byp_rd0", rd_data[31:0], 32'h12345678);
        chk("byp_rd1", rd_data[63:32], 32'h12345678);
        chk("nobyp_rd0", rd_data_nb[31:0], 32'h0);
        chk("nobyp_rd1", rd_data_nb[63:32], 32'h0);
        set_wr(1'b0, 5'd0, 32'h0);
        step();
        chk("nobyp_reread0", rd_data_nb[31:0], 32'h12345678);
        chk("nobyp_reread1", rd_data_nb[63:32], 32'h12345678);

        // write to r0 is suppressed and flagged for one cycle, no bypass
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(2'b11, 5'd0, 5'd0);
        step();
        chk("zero_err_pulse", {31'h0, wr_zero_err}, 32'h1);
        chk("zero_err_pulse_nb", {31'h0, wr_zero_err_nb}, 32'h1);
        chk("zero_same_rd0", rd_data[31:0], 32'h0);
        chk("zero_same_rd1", rd_data[63:32], 32'h0);
        set_wr(1'b0, 5'd0, 32'h0);
        step();
        chk("zero_err_clear", {31'h0, wr_zero_err}, 32'h0);
        chk("zero_later_rd0", rd_data[31:0], 32'h0);

        // port 1 stall holds its value across a write and address change
        set_wr(1'b1, 5'd3, 32'hA);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b11, 5'd5, 5'd3);
        step();
        chk("hold_load", rd_data[63:32], 32'hA);
        set_rd(2'b01, 5'd7, 5'd9);
        set_wr(1'b1, 5'd3, 32'hB);
        step();
        chk("hold_during_wr", rd_data[63:32], 32'hA);
        chk("hold_port0_live", rd_data[31:0], 32'h12345678);
        set_wr(1'b0, 5'd0, 32'h0);
        step();
        chk("hold_after_wr", rd_data[63:32], 32'hA);
        set_rd(2'b11, 5'd7, 5'd3);
        step();
        chk("hold_release", rd_data[63:32], 32'hB);

        // taps follow state after the write edge
        set_wr(1'b1, 5'd2, 32'h0000000A);
        step();
        chk("tap_a_wr", tap_a, 32'h0000000A);
        set_wr(1'b1, 5'd4, 32'h10010000);
        #1;
        chk("tap_b_before_edge", tap_b, 32'h0);
        step();
        chk("tap_b_wr", tap_b, 32'h10010000);
        chk("tap_a_kept", tap_a, 32'h0000000A);

        // asynchronous reset mid-cycle clears taps and held read data
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(2'b11, 5'd2, 5'd4);
        step();
        chk("pre_rst_rd0", rd_data[31:0], 32'h0000000A);
        chk("pre_rst_rd1", rd_data[63:32], 32'h10010000);
        set_rd(2'b00, 5'd6, 5'd6);
        set_wr(1'b1, 5'd6, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rd0", rd_data[31:0], 32'h0);
        chk("async_rst_rd1", rd_data[63:32], 32'h0);
        chk("async_rst_tap_a", tap_a, 32'h0);
        chk("async_rst_tap_b", tap_b, 32'h0);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        set_rd(2'b11, 5'd6, 5'd5);
        step();
        chk("rst_discard_r6", rd_data[31:0], 32'h0);
        chk("rst_cleared_r5", rd_data[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
